serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 Port: a  input  WIDTH  operand A; captured only when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B; captured only when start is accepted.
REQ-007 Port: carry_in  input  1  initial carry; captured only when start is accepted.
REQ-008 Port: busy  output  1  high whenever state is not IDLE.
REQ-009 Port: done  output  1  one-cycle pulse marking a completed result.
REQ-010 Port: sum  output  WIDTH  registered result.
REQ-011 Port: carry_out  output  1  registered final carry.

Function
REQ-012 The block SHALL compute a + b + carry_in bit-serially, LSB first, through one FullAdder instance, one bit per clk cycle.
REQ-013 States SHALL be IDLE, SHIFT and DONE.
REQ-014 Transitions SHALL be:
- IDLE->SHIFT on start==1.
- SHIFT->SHIFT while bit counter < WIDTH-1.
- SHIFT->DONE when counter == WIDTH-1.
- DONE->IDLE unconditionally.
REQ-015 On accepting start, the block SHALL:
- load A and B shift registers from a and b;
- load the carry register from carry_in;
- clear the bit counter;
- clear the internal sum shift register.
REQ-016 Each SHIFT cycle SHALL:
- add A[0], B[0] and the carry register;
- shift the sum bit into the internal sum register at the MSB;
- store the new carry;
- shift A and B right by one;
- increment the counter.
REQ-017 The sum and carry_out outputs SHALL update only on the SHIFT->DONE edge, and SHALL then hold until the next SHIFT->DONE edge or reset.
REQ-018 Latency: if start is sampled at edge E0, done SHALL be high between edges E(WIDTH) and E(WIDTH+1), with the final sum and carry_out valid in that cycle.
REQ-019 done SHALL be high only in state DONE, for exactly one cycle per accepted start.
REQ-020 start asserted while busy==1, including in DONE, SHALL be ignored and SHALL NOT disturb operands or the counter.
REQ-021 start asserted in the IDLE cycle immediately after DONE SHALL be accepted; the back-to-back issue interval is WIDTH+2 cycles.
REQ-022 Changes on a, b and carry_in after acceptance SHALL NOT affect the result.
REQ-023 Wrap-around: the result SHALL be modulo 2^WIDTH, with overflow reported only on carry_out.

Reset
REQ-024 While reset is high, the block SHALL asynchronously force:
- state=IDLE, busy=0, done=0;
- sum=0, carry_out=0;
- counter, carry register and all shift registers = 0.
REQ-025 Reset asserted mid-operation SHALL abandon the operation with no done pulse; the previous sum and carry_out are cleared to 0.
REQ-026 The first start after reset deassertion SHALL be accepted on the first rising clk edge at which reset is low.

Structure
REQ-027 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant SHALL live in the shared package adder_ctrl_pkg.
REQ-028 The bit adder SHALL be the existing FullAdder module, instantiated once, with port order (carry, sum, a, b, cin); no other sub-module.
REQ-029 The counter width SHALL be clog2(WIDTH), and the block SHALL be synthesizable with no latches.

Verification (WIDTH=8)
REQ-030 a=0x5A, b=0x3C, carry_in=0, start one cycle -> done pulse 8 cycles after the start edge, sum=0x96, carry_out=0.
REQ-031 a=0xFF, b=0x01, carry_in=0 -> sum=0x00, carry_out=1; a=0xFF, b=0xFF, carry_in=1 -> sum=0xFF, carry_out=1.
REQ-032 start pulsed again 3 cycles and 9 cycles after an accepted start (busy high) -> single done pulse, result unchanged; operands changed mid-operation -> result unchanged.
REQ-033 reset asserted 4 cycles into an operation -> busy, done, sum and carry_out read 0 immediately (asynchronously), no done pulse; next start yields the correct result.
REQ-034 start held high continuously with a=0x01, b=0x01, carry_in=0 -> done pulses every 10 cycles, sum=0x02 each time, busy low for exactly one cycle between operations.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings, the default operand width and a counter-width helper.
package adder_ctrl_pkg;

   // Default operand width in bits (legal range 2..32).
   localparam int unsigned DEFAULT_WIDTH = 8;

   // Controller states with fixed encodings.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Bit-counter width for a given operand width: clog2(w), never below 1.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/FullAdder.sv
// Single-bit full adder used as the datapath of the serial adder.
module FullAdder (
   output logic carry,
   output logic sum,
   input  logic a,
   input  logic b,
   input  logic cin
);

   // Sum is the parity of the inputs; carry is their majority.
   always_comb begin
      sum   = a ^ b ^ cin;
      carry = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: computes a + b + carry_in one bit per clock,
// LSB first, through a single FullAdder, and presents the registered result
// with a one-cycle done pulse.
module serial_adder_ctrl
   import adder_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int unsigned    CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q,     state_d;
   logic [WIDTH-1:0] a_sr_q,      a_sr_d;
   logic [WIDTH-1:0] b_sr_q,      b_sr_d;
   // Holds the first WIDTH-1 sum bits; the last bit comes straight from the
   // adder on the final SHIFT cycle, so a full WIDTH-bit register is not needed.
   logic [WIDTH-2:0] sum_sr_q,    sum_sr_d;
   logic             carry_q,     carry_d;
   logic [CW-1:0]    cnt_q,       cnt_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic [WIDTH-1:0] sum_q,       sum_d;
   logic             carry_out_q, carry_out_d;

   logic             fa_sum;
   logic             fa_carry;
   logic [WIDTH-1:0] sum_shift;

   FullAdder u_fa (
      .carry (fa_carry),
      .sum   (fa_sum),
      .a     (a_sr_q[0]),
      .b     (b_sr_q[0]),
      .cin   (carry_q)
   );

   // Next-state and datapath: load on accepted start, one bit per SHIFT cycle,
   // publish the result on the last SHIFT cycle.
   always_comb begin
      state_d     = state_q;
      a_sr_d      = a_sr_q;
      b_sr_d      = b_sr_q;
      sum_sr_d    = sum_sr_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      sum_d       = sum_q;
      carry_out_d = carry_out_q;
      sum_shift   = {fa_sum, sum_sr_q};

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d  = SHIFT;
               busy_d   = 1'b1;
               a_sr_d   = a;
               b_sr_d   = b;
               carry_d  = carry_in;
               cnt_d    = '0;
               sum_sr_d = '0;
            end
         end

         SHIFT: begin
            busy_d   = 1'b1;
            sum_sr_d = sum_shift[WIDTH-1:1];
            carry_d  = fa_carry;
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               state_d     = DONE;
               done_d      = 1'b1;
               sum_d       = sum_shift;
               carry_out_d = fa_carry;
            end
         end

         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         a_sr_q      <= '0;
         b_sr_q      <= '0;
         sum_sr_q    <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sum_q       <= '0;
         carry_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sr_q      <= a_sr_d;
         b_sr_q      <= b_sr_d;
         sum_sr_q    <= sum_sr_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sum_q       <= sum_d;
         carry_out_q <= carry_out_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign sum       = sum_q;
   assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic
// reference: result = a + b + carry_in, done exactly WIDTH edges after start.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carry_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry_out;

   int errors = 0;
   int checks = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Runs one addition starting from an IDLE negedge; optionally pulses start
   // 3 and W+1 edges after acceptance. Operands are scrambled after acceptance.
   task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic op_cin, input bit interfere);
      logic [W:0]   ref_v;
      logic [W-1:0] got_sum;
      logic         got_co;
      int           done_at;
      int           pulses;
      int           busy_low;
      ref_v    = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin};
      got_sum  = 'x;
      got_co   = 1'bx;
      done_at  = -1;
      pulses   = 0;
      busy_low = 0;
      a = op_a; b = op_b; carry_in = op_cin; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      for (int n = 1; n <= W + 1; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            pulses++;
            if (done_at < 0) begin
               done_at = n;
               got_sum = sum;
               got_co  = carry_out;
            end
         end
         if (n <= W && busy !== 1'b1) busy_low++;
         if (interfere && (n == 2 || n == W)) begin
            start = 1'b1; a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      check("done_latency", done_at, W);
      check("done_pulses", pulses, 1);
      check("busy_held", busy_low, 0);
      check("sum_at_done", {24'd0, got_sum}, {24'd0, ref_v[W-1:0]});
      check("carry_at_done", {31'd0, got_co}, {31'd0, ref_v[W]});
      check("busy_after_done", {31'd0, busy}, 32'd0);
      check("sum_hold", {24'd0, sum}, {24'd0, ref_v[W-1:0]});
      if (interfere) begin
         @(negedge clk);
         check("ignored_start_idle", {31'd0, busy}, 32'd0);
         check("ignored_start_done", {31'd0, done}, 32'd0);
      end
   endtask

   initial begin
      int prev;
      int low_run;
      int ndone;
      int spurious;
      int waited;

      reset = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", {24'd0, sum}, 32'd0);
      check("rst_carry", {31'd0, carry_out}, 32'd0);
      reset = 1'b0;

      // First start right after reset release, then directed vectors.
      run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
      run_op(8'h00, 8'h00, 1'b0, 1'b0);
      run_op(8'h12, 8'h34, 1'b1, 1'b1);

      // Randomized operations with random spacing and interfering starts.
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      end

      // Reset in mid-operation: outputs clear asynchronously, no done pulse.
      run_op(8'h80, 8'h81, 1'b1, 1'b0);
      a = 8'h0F; b = 8'hF0; carry_in = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_sum", {24'd0, sum}, 32'd0);
      check("midrst_carry", {31'd0, carry_out}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      spurious = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) spurious++;
      end
      check("midrst_no_done", spurious, 0);
      run_op(8'hA5, 8'h5A, 1'b1, 1'b0);

      // Start held high: back-to-back operations every W+2 cycles.
      a = 8'h01; b = 8'h01; carry_in = 1'b0; start = 1'b1;
      prev = -1; low_run = 0; ndone = 0;
      for (int n = 1; n <= 45; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            check("b2b_sum", {24'd0, sum}, 32'h02);
            check("b2b_carry", {31'd0, carry_out}, 32'd0);
            if (prev >= 0) check("b2b_interval", n - prev, W + 2);
            prev = n;
            ndone++;
         end
         if (busy !== 1'b1) begin
            low_run++;
         end else begin
            if (low_run > 0) check("b2b_idle_gap", low_run, 1);
            low_run = 0;
         end
      end
      check("b2b_count", ndone, 4);
      start = 1'b0;
      waited = 0;
      while (busy !== 1'b0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("drain_idle", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
